bg_fetch: RTL and testbench

BG_FETCH -- requirements
Module: bg_fetch

---
 rtl/vga_pkg.sv | 11 +
 rtl/bg_addr_gen.sv | 53 +++++
 rtl/bg_fetch.sv | 71 +++++++
 tb/tb_bg_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen and background-image geometry for the VGA background path.
package vga_pkg;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned ADDR_WIDTH = 17;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned SCROLL_W   = 9;
endpackage

// File: rtl/bg_addr_gen.sv
// Combinational screen-pixel to background-SRAM address mapping with
// 2x upscale, frame-start scroll selection and horizontal wrap.
module bg_addr_gen #(
  parameter int unsigned IMG_W      = vga_pkg::IMG_W,
  parameter int unsigned IMG_H      = vga_pkg::IMG_H,
  parameter int unsigned ADDR_WIDTH = vga_pkg::ADDR_WIDTH
) (
  input  logic                  pixel_tick,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic [8:0]            scroll_x,
  input  logic [8:0]            scroll_eff,
  output logic                  frame_start,
  output logic [8:0]            scroll_new,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [8:0]  W9  = 9'(IMG_W);
  localparam logic [9:0]  W10 = 10'(IMG_W);
  localparam logic [31:0] W32 = 32'(IMG_W);
  localparam logic [8:0]  H9  = 9'(IMG_H);

  logic [8:0]            scroll_sel;
  logic [8:0]            img_row;
  logic [8:0]            img_col;
  logic [9:0]            col_sum;
  logic [9:0]            col;
  logic [ADDR_WIDTH-1:0] row_base;

  always_comb begin
    frame_start = pixel_tick && (pixel_x == '0) && (pixel_y == '0);
    scroll_new  = (scroll_x >= W9) ? scroll_x - W9 : scroll_x;
    // The frame's first pixel already uses the value being latched.
    scroll_sel  = frame_start ? scroll_new : scroll_eff;

    img_col = pixel_x[9:1];
    img_row = (pixel_y[9:1] >= H9) ? H9 - 9'd1 : pixel_y[9:1];

    col_sum = {1'b0, img_col} + {1'b0, scroll_sel};
    col     = (col_sum >= W10) ? col_sum - W10 : col_sum;

    // Constant multiply by IMG_W as a sum of shifted rows (row<<8 + row<<6 for 320).
    row_base = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (W32[i]) begin
        row_base = row_base + (ADDR_WIDTH'(img_row) << i);
      end
    end

    addr = row_base + ADDR_WIDTH'(col);
  end

endmodule

// File: rtl/bg_fetch.sv
// Background fetch: scrolled, 2x upscaled image read from SRAM with a
// two-clock pixel_tick-to-rgb_out pipeline.
module bg_fetch #(
  parameter int unsigned IMG_W      = vga_pkg::IMG_W,
  parameter int unsigned IMG_H      = vga_pkg::IMG_H,
  parameter int unsigned ADDR_WIDTH = vga_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = vga_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_tick,
  input  logic                  video_on,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic [8:0]            scroll_x,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_en,
  output logic                  sram_we,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic [DATA_WIDTH-1:0] rgb_out,
  output logic                  rgb_valid
);

  logic                  frame_start;
  logic [8:0]            scroll_new;
  logic [8:0]            scroll_eff;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  v0;
  logic                  v1;

  bg_addr_gen #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .pixel_tick  (pixel_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .scroll_x    (scroll_x),
    .scroll_eff  (scroll_eff),
    .frame_start (frame_start),
    .scroll_new  (scroll_new),
    .addr        (addr_next)
  );

  assign sram_en = reset_n;
  assign sram_we = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sram_addr  <= '0;
      scroll_eff <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      rgb_out    <= '0;
      rgb_valid  <= 1'b0;
    end else begin
      if (pixel_tick) begin
        sram_addr <= addr_next;
      end
      if (frame_start) begin
        scroll_eff <= scroll_new;
      end
      v0        <= pixel_tick & video_on;
      v1        <= v0;
      rgb_out   <= v1 ? sram_data : '0;
      rgb_valid <= v1;
    end
  end

endmodule

// File: tb/tb_bg_fetch.sv
// Self-checking bench for bg_fetch: directed scenarios plus random traffic
// against a per-cycle arithmetic reference model and a synchronous SRAM model.
module tb_bg_fetch;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int HIST_N = 4096;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        video_on   = 1'b0;
  logic [9:0]  pixel_x    = '0;
  logic [9:0]  pixel_y    = '0;
  logic [8:0]  scroll_x   = '0;
  logic [16:0] sram_addr;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_data  = '0;
  logic [11:0] rgb_out;
  logic        rgb_valid;

  int errors = 0;
  int checks = 0;

  logic [11:0] mem [0:IMG_W*IMG_H-1];

  // Reference model state: effective scroll, expected address, per-cycle history.
  int m_scroll = 0;
  int m_addr   = 0;
  int t        = 2;
  bit hv [0:HIST_N-1];
  bit hr [0:HIST_N-1];
  int ha [0:HIST_N-1];

  bg_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .scroll_x   (scroll_x),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_data  (sram_data),
    .rgb_out    (rgb_out),
    .rgb_valid  (rgb_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_data <= mem[sram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input bit rn, input bit tick, input bit von,
                     input int x, input int y);
    bit exp_v;
    int exp_rgb;
    @(negedge clk);
    reset_n    = rn;
    pixel_tick = tick;
    video_on   = von;
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    @(posedge clk);
    t++;
    if (t >= HIST_N) begin
      $display("FAIL history: cycle index %0d exceeds %0d", t, HIST_N);
      $fatal(1, "history overflow");
    end
    if (!rn) begin
      m_scroll = 0;
      m_addr   = 0;
      hv[t]    = 0;
      hr[t]    = 1;
    end else begin
      hr[t] = 0;
      if (tick && x == 0 && y == 0) m_scroll = int'(scroll_x) % IMG_W;
      if (tick) m_addr = (y / 2) * IMG_W + ((x / 2) + m_scroll) % IMG_W;
      hv[t] = tick && von;
    end
    ha[t] = m_addr;
    #1;
    exp_v   = !hr[t] && !hr[t-1] && hv[t-2];
    exp_rgb = exp_v ? int'(mem[ha[t-2]]) : 0;
    check({tag, " addr"},  32'(sram_addr), 32'(m_addr));
    check({tag, " en"},    32'(sram_en),   32'(rn));
    check({tag, " we"},    32'(sram_we),   32'(0));
    check({tag, " valid"}, 32'(rgb_valid), 32'(exp_v));
    check({tag, " rgb"},   32'(rgb_out),   32'(exp_rgb));
  endtask

  initial begin
    int x;
    int y;
    bit rn;
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 12'($urandom);
    for (int i = 0; i < HIST_N; i++) begin
      hv[i] = 0;
      hr[i] = 1;
      ha[i] = 0;
    end

    // Reset with activity on the inputs.
    for (int i = 0; i < 3; i++) cyc("reset", 0, 1, 1, 4, 4);

    // First pixel of a frame with no scroll, then its data two clocks later.
    scroll_x = 9'd0;
    cyc("r022", 1, 1, 1, 0, 0);
    check("r022 addr0", 32'(sram_addr), 32'(0));
    cyc("r022 gap", 1, 0, 1, 1, 0);
    cyc("r022 gap", 1, 0, 1, 1, 0);
    check("r022 valid", 32'(rgb_valid), 32'(1));
    check("r022 word0", 32'(rgb_out), 32'(mem[0]));

    // Last visible pixel.
    cyc("r023", 1, 1, 1, 639, 479);
    check("r023 last", 32'(sram_addr), 32'(76799));

    // Small scroll with wrap.
    scroll_x = 9'd10;
    cyc("r024 fs", 1, 1, 1, 0, 0);
    check("r024 fs addr", 32'(sram_addr), 32'(10));
    cyc("r024 wrap", 1, 1, 1, 630, 0);
    check("r024 wrap addr", 32'(sram_addr), 32'(5));
    cyc("r024 row1", 1, 1, 1, 0, 2);
    check("r024 row1 addr", 32'(sram_addr), 32'(330));

    // Scroll beyond IMG_W, then a mid-frame change that must be ignored.
    scroll_x = 9'd400;
    cyc("r025 fs", 1, 1, 1, 0, 0);
    check("r025 eff80", 32'(sram_addr), 32'(80));
    scroll_x = 9'd0;
    cyc("r025 mid", 1, 1, 1, 2, 0);
    check("r025 held scroll", 32'(sram_addr), 32'(81));
    cyc("r025 mid", 1, 1, 1, 100, 10);

    // Blanking ticks and tick gaps.
    for (int i = 0; i < 4; i++) cyc("r026 blank", 1, 1, 0, 640 + 10 * i, 10);
    check("r026 blank rgb", 32'(rgb_out), 32'(0));
    check("r026 blank valid", 32'(rgb_valid), 32'(0));
    cyc("r026 tick", 1, 1, 1, 20, 20);
    for (int i = 0; i < 3; i++) cyc("r026 gap", 1, 0, 1, 300, 300);

    // Right-edge wrap at maximum scroll on the bottom line.
    scroll_x = 9'd511;
    cyc("edge fs", 1, 1, 1, 0, 0);
    for (int xx = 600; xx < 640; xx += 2) cyc("edge line", 1, 1, 1, xx, 479);
    check("edge last", 32'(sram_addr), 32'(76670));

    // Reset mid-line with both pipeline stages full; scroll must restart at 0.
    scroll_x = 9'd37;
    cyc("r027 fs", 1, 1, 1, 0, 0);
    cyc("r027 a", 1, 1, 1, 200, 50);
    cyc("r027 b", 1, 1, 1, 202, 50);
    cyc("r027 rst", 0, 1, 1, 204, 50);
    cyc("r027 post1", 1, 0, 1, 206, 50);
    check("r027 flush valid", 32'(rgb_valid), 32'(0));
    check("r027 flush rgb", 32'(rgb_out), 32'(0));
    cyc("r027 post2", 1, 1, 1, 208, 50);
    cyc("r027 post3", 1, 0, 1, 210, 50);
    cyc("r027 post4", 1, 0, 1, 210, 50);
    check("r027 resume valid", 32'(rgb_valid), 32'(1));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) scroll_x = 9'($urandom);
      rn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 9) == 0) begin
        x = 0;
        y = 0;
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      cyc("rand", rn, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), x, y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
